// File: rtl/mode_control.sv
// Button front end for pulse_generator: synchronises and debounces up/down/clear buttons,
// steps a pending mode and commits it to the mode output only on a PWM period boundary.

module mode_debounce #(
  parameter int DB_CYCLES     = 16,
  parameter int CNT_W         = 20,
  parameter int REPEAT_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       level,
  output logic       press,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rpt_q, rpt_d;

  assign state = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      rpt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rpt_q   <= rpt_d;
    end
  end

  // rpt_d defaults to zero so the repeat timer restarts whenever HELD is left
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rpt_d   = '0;
    press   = 1'b0;
    case (state_q)
      RELEASED: begin
        if (level) begin
          if (DB_CYCLES <= 1) begin
            state_d = HELD;
            cnt_d   = '0;
            press   = 1'b1;
          end else begin
            state_d = PRESS_WAIT;
            cnt_d   = ONE;
          end
        end
      end
      PRESS_WAIT: begin
        if (!level) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q >= DB_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          press   = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      HELD: begin
        if (!level) begin
          if (DB_CYCLES <= 1) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end else begin
            state_d = RELEASE_WAIT;
            cnt_d   = ONE;
          end
        end else if (REPEAT_CYCLES > 0) begin
          if (rpt_q >= RPT_LAST) begin
            press = 1'b1;
            rpt_d = '0;
          end else begin
            rpt_d = rpt_q + ONE;
          end
        end
      end
      RELEASE_WAIT: begin
        if (level) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q >= DB_LAST) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

module mode_control #(
  parameter int DB_CYCLES     = 16,
  parameter int CNT_W         = 20,
  parameter int REPEAT_CYCLES = 0,
  parameter int MODE_MAX      = 15,
  parameter int WRAP          = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_clr,
  input  logic       period_end,
  output logic [3:0] mode,
  output logic       mode_changed,
  output logic       pending,
  output logic [5:0] debug_state
);

  localparam logic [3:0] MAX_M = 4'(MODE_MAX);

  logic [2:0] sync1, sync2;
  logic       ev_up, ev_dn, ev_clr;
  logic [3:0] pend_q, pend_d;

  // bit order in the synchroniser and debug bus: {clr, down, up}
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {btn_clr, btn_down, btn_up};
      sync2 <= sync1;
    end
  end

  mode_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W), .REPEAT_CYCLES(REPEAT_CYCLES)) u_db_up (
    .clk(clk), .rst(rst), .level(sync2[0]), .press(ev_up), .state(debug_state[1:0])
  );

  mode_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W), .REPEAT_CYCLES(REPEAT_CYCLES)) u_db_down (
    .clk(clk), .rst(rst), .level(sync2[1]), .press(ev_dn), .state(debug_state[3:2])
  );

  mode_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W), .REPEAT_CYCLES(0)) u_db_clr (
    .clk(clk), .rst(rst), .level(sync2[2]), .press(ev_clr), .state(debug_state[5:4])
  );

  always_comb begin
    pend_d = pend_q;
    if (ev_clr) begin
      pend_d = 4'd0;
    end else if (ev_up && !ev_dn) begin
      if (pend_q >= MAX_M) pend_d = (WRAP != 0) ? 4'd0 : MAX_M;
      else                 pend_d = pend_q + 4'd1;
    end else if (ev_dn && !ev_up) begin
      if (pend_q == 4'd0)  pend_d = (WRAP != 0) ? MAX_M : 4'd0;
      else                 pend_d = pend_q - 4'd1;
    end
  end

  // commit samples pend_q, i.e. the value before any event landing on this same edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q       <= 4'd0;
      mode         <= 4'd0;
      mode_changed <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      mode_changed <= 1'b0;
      if (period_end && (pend_q != mode)) begin
        mode         <= pend_q;
        mode_changed <= 1'b1;
      end
    end
  end

  assign pending = (pend_q != mode);

endmodule

// File: tb/tb_mode_control.sv
// Directed bench for mode_control: three instances cover wrap, saturate and auto-repeat builds.

module tb_mode_control;

  logic       clk;
  logic       rst;
  logic [2:0] up, dn, cl, pe;
  logic [3:0] mode_o [3];
  logic [5:0] dbg_o  [3];
  logic [2:0] chg, pnd;

  int checks;
  int failures;

  mode_control #(.DB_CYCLES(4), .CNT_W(20), .REPEAT_CYCLES(0), .MODE_MAX(15), .WRAP(1)) dut_wrap (
    .clk(clk), .rst(rst), .btn_up(up[0]), .btn_down(dn[0]), .btn_clr(cl[0]),
    .period_end(pe[0]), .mode(mode_o[0]), .mode_changed(chg[0]), .pending(pnd[0]),
    .debug_state(dbg_o[0])
  );

  mode_control #(.DB_CYCLES(4), .CNT_W(20), .REPEAT_CYCLES(0), .MODE_MAX(15), .WRAP(0)) dut_sat (
    .clk(clk), .rst(rst), .btn_up(up[1]), .btn_down(dn[1]), .btn_clr(cl[1]),
    .period_end(pe[1]), .mode(mode_o[1]), .mode_changed(chg[1]), .pending(pnd[1]),
    .debug_state(dbg_o[1])
  );

  mode_control #(.DB_CYCLES(4), .CNT_W(20), .REPEAT_CYCLES(8), .MODE_MAX(15), .WRAP(1)) dut_rpt (
    .clk(clk), .rst(rst), .btn_up(up[2]), .btn_down(dn[2]), .btn_clr(cl[2]),
    .period_end(pe[2]), .mode(mode_o[2]), .mode_changed(chg[2]), .pending(pnd[2]),
    .debug_state(dbg_o[2])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checker
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // b = {clr, down, up}; held n cycles, then released long enough to fully debounce
  task automatic press(input int i, input logic [2:0] b, input int n);
    cl[i] = b[2];
    dn[i] = b[1];
    up[i] = b[0];
    repeat (n) step();
    cl[i] = 1'b0;
    dn[i] = 1'b0;
    up[i] = 1'b0;
    repeat (12) step();
  endtask

  task automatic commit(input int i);
    pe[i] = 1'b1;
    step();
    pe[i] = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b0;
    up  = '0;
    dn  = '0;
    cl  = '0;
    pe  = '0;
    repeat (3) step();

    // reset state
    for (int i = 0; i < 3; i++) begin
      check("rst_mode", mode_o[i], 0);
      check("rst_changed", chg[i], 0);
      check("rst_pending", pnd[i], 0);
      check("rst_dbg", dbg_o[i], 0);
    end
    rst = 1'b1;
    step();

    // single debounced up press, then commit
    up[0] = 1'b1;
    repeat (10) step();
    check("t1_up_held_state", dbg_o[0][1:0], 2);
    up[0] = 1'b0;
    repeat (12) step();
    check("t1_up_released_state", dbg_o[0][1:0], 0);
    check("t1_pending", pnd[0], 1);
    check("t1_mode_before", mode_o[0], 0);
    commit(0);
    check("t1_mode", mode_o[0], 1);
    check("t1_changed", chg[0], 1);
    check("t1_pending_after", pnd[0], 0);
    step();
    check("t1_changed_one_cycle", chg[0], 0);

    // glitches of 1..3 cycles never debounce
    for (int n = 1; n <= 3; n++) begin
      up[0] = 1'b1;
      repeat (n) step();
      up[0] = 1'b0;
      repeat (5) step();
    end
    repeat (10) step();
    check("t2_glitch_pending", pnd[0], 0);
    check("t2_glitch_mode", mode_o[0], 1);

    // event landing on the same edge as period_end is held for the next boundary
    up[0] = 1'b1;
    repeat (5) step();
    pe[0] = 1'b1;
    step();
    pe[0] = 1'b0;
    check("t2b_same_edge_mode", mode_o[0], 1);
    check("t2b_same_edge_changed", chg[0], 0);
    check("t2b_same_edge_pending", pnd[0], 1);
    up[0] = 1'b0;
    repeat (12) step();
    commit(0);
    check("t2b_next_commit_mode", mode_o[0], 2);
    check("t2b_next_commit_changed", chg[0], 1);

    // three ups and a down accumulate into one commit: 2 + 3 - 1 = 4
    press(0, 3'b001, 8);
    press(0, 3'b001, 8);
    press(0, 3'b001, 8);
    press(0, 3'b010, 8);
    check("t4_pending", pnd[0], 1);
    check("t4_mode_before", mode_o[0], 2);
    commit(0);
    check("t4_mode", mode_o[0], 4);
    check("t4_changed", chg[0], 1);
    step();
    check("t4_changed_drop", chg[0], 0);
    commit(0);
    check("t4_equal_no_pulse", chg[0], 0);
    check("t4_equal_mode", mode_o[0], 4);

    // simultaneous up+down is a no-op, clr beats up
    press(0, 3'b011, 8);
    check("t5_updown_pending", pnd[0], 0);
    press(0, 3'b101, 8);
    check("t5_clr_pending", pnd[0], 1);
    commit(0);
    check("t5_clr_mode", mode_o[0], 0);
    check("t5_clr_changed", chg[0], 1);

    // wrap both ways
    press(0, 3'b010, 8);
    commit(0);
    check("t3_wrap_down_mode", mode_o[0], 15);
    press(0, 3'b001, 8);
    check("t3_wrap_up_pending", pnd[0], 1);
    commit(0);
    check("t3_wrap_up_mode", mode_o[0], 0);
    check("t3_wrap_up_changed", chg[0], 1);

    // saturating build
    press(1, 3'b010, 8);
    check("t3s_down_at_zero", pnd[1], 0);
    for (int k = 0; k < 15; k++) press(1, 3'b001, 8);
    commit(1);
    check("t3s_mode_15", mode_o[1], 15);
    press(1, 3'b001, 8);
    check("t3s_up_at_max_pending", pnd[1], 0);
    commit(1);
    check("t3s_up_at_max_changed", chg[1], 0);
    check("t3s_up_at_max_mode", mode_o[1], 15);

    // auto-repeat with period_end every cycle
    pe[2] = 1'b1;
    up[2] = 1'b1;
    repeat (7) step();
    check("t6_first_step", mode_o[2], 1);
    repeat (7) step();
    check("t6_before_repeat", mode_o[2], 1);
    step();
    check("t6_repeat_1", mode_o[2], 2);
    check("t6_repeat_1_changed", chg[2], 1);
    repeat (8) step();
    check("t6_repeat_2", mode_o[2], 3);
    repeat (8) step();
    check("t6_repeat_3", mode_o[2], 4);

    // asynchronous reset mid-hold, away from any clock edge
    #2;
    rst = 1'b0;
    #1;
    check("t6_async_rst_mode", mode_o[2], 0);
    check("t6_async_rst_pending", pnd[2], 0);
    check("t6_async_rst_changed", chg[2], 0);
    check("t6_async_rst_other_mode", mode_o[1], 0);
    up[2] = 1'b0;
    pe[2] = 1'b0;
    step();
    rst = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
